// File: rtl/pm_datapath.sv
// pm_datapath -- small register-file datapath with one ALU and a registered output.
//
// Four WIDTH-bit registers R0..R3. R0 is the accumulator: it is operand B of the ALU
// and is written from a priority-selected source. R1..R3 form a shift chain fed by R0.
// Operand A of the ALU is din or one of R1..R3. Carry and zero flags are registered.
// The output register samples R0 on demand, so dout always lags R0 by one edge.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset of all state
//   clr        in   synchronous clear of R0..R3 and the flags (dout untouched)
//   ce[3:0]    in   per-register enables, ce[k] -> Rk
//   w[2:0]     in   R0 write source: w[2] ALU, else w[1] din, else w[0] zero, else hold
//   s[2:0]     in   ALU operation
//   sel[1:0]   in   operand A: din, R1, R2, R3
//   en         in   capture R0 into dout
//   din        in   external operand
//   dout       out  captured R0
//   dout_valid out  dout has been captured at least once since reset
//   carry      out  registered ALU carry/borrow
//   zero       out  registered (R0 == 0)
module pm_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [3:0]       ce,
    input  logic [2:0]       w,
    input  logic [2:0]       s,
    input  logic [1:0]       sel,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             carry,
    output logic             zero
);

    logic [3:0][WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0]      dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  carry_q, carry_d;
    logic                  zero_q, zero_d;

    logic [WIDTH-1:0]      op_a;
    logic [WIDTH-1:0]      alu_y;
    logic                  alu_c;
    logic [WIDTH-1:0]      wdata;

    // Returns {carry_out, result}. All arithmetic wraps modulo 2^WIDTH.
    function automatic logic [WIDTH:0] alu(input logic [2:0]       op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        logic [WIDTH:0] res;
        res = '0;
        case (op)
            3'b000: res = {1'b0, b};
            3'b001: res = {1'b0, a} + {1'b0, b};
            3'b010: res = {1'b0, a};
            3'b011: res = {(b < a), WIDTH'(b - a)};
            3'b100: res = {1'b0, a & b};
            3'b101: res = {1'b0, a | b};
            3'b110: res = {1'b0, a ^ b};
            default: res = {b[WIDTH-1], b[WIDTH-2:0], 1'b0};
        endcase
        return res;
    endfunction

    always_comb begin
        op_a = din;
        case (sel)
            2'b00:   op_a = din;
            2'b01:   op_a = r_q[1];
            2'b10:   op_a = r_q[2];
            default: op_a = r_q[3];
        endcase

        {alu_c, alu_y} = alu(s, op_a, r_q[0]);

        // w = 000 never reaches wdata: the write is suppressed below.
        if (w[2])      wdata = alu_y;
        else if (w[1]) wdata = din;
        else           wdata = '0;

        r_d     = r_q;
        carry_d = carry_q;
        zero_d  = zero_q;

        if (clr) begin
            r_d     = '0;
            carry_d = 1'b0;
            zero_d  = 1'b1;
        end else begin
            if (ce[0] && (w != 3'b000)) begin
                r_d[0] = wdata;
                zero_d = (wdata == '0);
            end
            if (ce[0] && w[2]) begin
                carry_d = alu_c;
            end
            // Chain reads r_q, so shifts use pre-edge values alongside the R0 write.
            for (int k = 1; k < 4; k++) begin
                if (ce[k]) r_d[k] = r_q[k-1];
            end
        end

        dout_d       = en ? r_q[0] : dout_q;
        dout_valid_d = dout_valid_q | en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q          <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b1;
        end else begin
            r_q          <= r_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            carry_q      <= carry_d;
            zero_q       <= zero_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign carry      = carry_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_pm_datapath.sv
// Directed testbench for pm_datapath (WIDTH=8). R0 is observed by capturing it into dout.
module tb_pm_datapath;

    logic       clk = 1'b0;
    logic       reset, clr, en;
    logic [3:0] ce;
    logic [2:0] w, s;
    logic [1:0] sel;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid, carry, zero;

    int n_chk  = 0;
    int n_fail = 0;

    pm_datapath #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .clr(clr), .ce(ce), .w(w), .s(s), .sel(sel),
        .en(en), .din(din), .dout(dout), .dout_valid(dout_valid),
        .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Apply one set of controls for one edge.
    task automatic op(input logic [3:0] ce_i, input logic [2:0] w_i, input logic [2:0] s_i,
                      input logic [1:0] sel_i, input logic [7:0] din_i);
        ce = ce_i; w = w_i; s = s_i; sel = sel_i; din = din_i;
        cyc();
    endtask

    // Capture R0 into dout without disturbing any register.
    task automatic peek(input string tag, input logic [7:0] exp);
        ce = 4'b0000; en = 1'b1;
        cyc();
        en = 1'b0;
        chk(tag, dout, exp);
        chk({tag, "_vld"}, dout_valid, 1);
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; en = 1'b0; ce = '0; w = '0; s = '0; sel = '0; din = '0;
        #12;
        chk("rst_dout", dout, 0);
        chk("rst_vld", dout_valid, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 1);
        @(negedge clk); reset = 1'b0;

        // Clear, then load chain: R0=03 R1=05 R2=07 R3=00
        clr = 1'b1; cyc(); clr = 1'b0;
        op(4'b1111, 3'b100, 3'b010, 2'b00, 8'h07);
        op(4'b1111, 3'b100, 3'b010, 2'b00, 8'h05);
        op(4'b1111, 3'b100, 3'b010, 2'b00, 8'h03);
        chk("load_zero", zero, 0);
        chk("load_carry", carry, 0);
        chk("load_vld", dout_valid, 0);

        // ADD R1: 03+05=08
        op(4'b0001, 3'b100, 3'b001, 2'b01, 8'h00);
        chk("acc_carry", carry, 0);
        peek("acc_r1", 8'h08);
        // ADD R2: 08+07=0F
        op(4'b0001, 3'b100, 3'b001, 2'b10, 8'h00);
        peek("acc_r2", 8'h0F);
        // SUB R1: 0F-05=0A, no borrow
        op(4'b0001, 3'b100, 3'b011, 2'b01, 8'h00);
        chk("sub_carry", carry, 0);
        peek("sub_nb", 8'h0A);
        // AND R2: 0A&07=02
        op(4'b0001, 3'b100, 3'b100, 2'b10, 8'h00);
        peek("and", 8'h02);
        // OR R1: 02|05=07
        op(4'b0001, 3'b100, 3'b101, 2'b01, 8'h00);
        peek("or", 8'h07);
        // XOR R2: 07^07=00
        op(4'b0001, 3'b100, 3'b110, 2'b10, 8'h00);
        chk("xor_zero", zero, 1);
        peek("xor", 8'h00);
        // Copy R3 (=00) into R0 after loading 44: zero must be set
        op(4'b0001, 3'b010, 3'b000, 2'b00, 8'h44);
        chk("din_zero", zero, 0);
        op(4'b0001, 3'b100, 3'b010, 2'b11, 8'h99);
        chk("r3_zero", zero, 1);

        // SHL: 81 -> 02, carry = old MSB
        op(4'b0001, 3'b010, 3'b000, 2'b00, 8'h81);
        chk("w010_carry_hold", carry, 0);
        op(4'b0001, 3'b100, 3'b111, 2'b00, 8'h00);
        chk("shl_carry", carry, 1);
        chk("shl_zero", zero, 0);
        peek("shl", 8'h02);
        // w=001 writes zero; carry holds
        op(4'b0001, 3'b001, 3'b001, 2'b00, 8'h77);
        chk("w001_zero", zero, 1);
        chk("w001_carry", carry, 1);
        // Priority: w=110 with s=B (R0=00) must not take din
        op(4'b0001, 3'b110, 3'b000, 2'b00, 8'h5A);
        chk("prio_w2_zero", zero, 1);
        chk("prio_w2_carry", carry, 0);
        // w=011: din beats zero
        op(4'b0001, 3'b011, 3'b000, 2'b00, 8'h5A);
        peek("prio_w1", 8'h5A);

        // Wrap: FF+01 = 00, carry, zero
        op(4'b0001, 3'b010, 3'b000, 2'b00, 8'hFF);
        op(4'b0001, 3'b100, 3'b001, 2'b00, 8'h01);
        chk("wrap_carry", carry, 1);
        chk("wrap_zero", zero, 1);
        peek("wrap", 8'h00);
        // Borrow: 02-03 = FF
        op(4'b0001, 3'b010, 3'b000, 2'b00, 8'h02);
        op(4'b0001, 3'b100, 3'b011, 2'b00, 8'h03);
        chk("borrow_carry", carry, 1);
        chk("borrow_zero", zero, 0);
        peek("borrow", 8'hFF);

        // clr overrides ce/w and leaves dout alone
        clr = 1'b1;
        op(4'b1111, 3'b010, 3'b001, 2'b00, 8'hAA);
        clr = 1'b0;
        chk("clr_zero", zero, 1);
        chk("clr_carry", carry, 0);
        chk("clr_dout", dout, 8'hFF);
        chk("clr_vld", dout_valid, 1);
        op(4'b0001, 3'b010, 3'b000, 2'b00, 8'h33);
        op(4'b0001, 3'b100, 3'b010, 2'b01, 8'h00);
        chk("clr_r1", zero, 1);
        op(4'b0001, 3'b010, 3'b000, 2'b00, 8'h33);
        op(4'b0001, 3'b100, 3'b010, 2'b11, 8'h00);
        chk("clr_r3", zero, 1);

        // en with simultaneous R0 write: dout gets old R0
        op(4'b0001, 3'b010, 3'b000, 2'b00, 8'h11);
        en = 1'b1;
        op(4'b0001, 3'b010, 3'b000, 2'b00, 8'h22);
        en = 1'b0;
        chk("sim_dout", dout, 8'h11);
        peek("sim_new", 8'h22);

        // Hold for 3 cycles
        op(4'b0000, 3'b100, 3'b001, 2'b00, 8'hFF);
        op(4'b0000, 3'b100, 3'b001, 2'b00, 8'hFF);
        op(4'b0000, 3'b100, 3'b001, 2'b00, 8'hFF);
        chk("hold_carry", carry, 0);
        chk("hold_zero", zero, 0);
        peek("hold_r0", 8'h22);
        // Chain only: R1 <- R0, R0 holds
        op(4'b0010, 3'b010, 3'b000, 2'b00, 8'h00);
        peek("chain_r0", 8'h22);
        op(4'b0001, 3'b010, 3'b000, 2'b00, 8'h00);
        op(4'b0001, 3'b100, 3'b010, 2'b01, 8'h00);
        peek("chain_r1", 8'h22);

        // 22+FF = 21 carry; then asynchronous reset between edges
        op(4'b0001, 3'b100, 3'b001, 2'b00, 8'hFF);
        chk("pre_rst_carry", carry, 1);
        peek("pre_rst", 8'h21);
        #2 reset = 1'b1;
        #1;
        chk("arst_dout", dout, 0);
        chk("arst_vld", dout_valid, 0);
        chk("arst_carry", carry, 0);
        chk("arst_zero", zero, 1);
        #1 reset = 1'b0;
        peek("post_rst", 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
